// File: rtl/ibuff_mem_ctrl.sv
// ibuff_mem_ctrl: queues fetch requests and reads each 64-bit instruction
// word as two 32-bit memory reads (addr, then addr+4). Responses are
// returned to the wavepool in request order as {instr, tag}.
// Optional build macro IBUFF_PERF_CNT_EN adds accepted-request and
// grant-stall performance counters.
module ibuff_mem_ctrl #(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        buff_rd_en,
    input  logic [31:0] buff_addr,
    input  logic [38:0] buff_tag,
    output logic        buff_ack,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rd_valid,
    input  logic [31:0] mem_rd_data,
    output logic        buff2wave_valid,
    output logic [63:0] buff2wave_instr,
    output logic [38:0] buff2wave_tag,
    output logic        ibuff_overflow
`ifdef IBUFF_PERF_CNT_EN
    ,
    output logic [31:0] perf_req_cnt,
    output logic [31:0] perf_stall_cnt
`endif
);

    localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ_LO  = 3'd1,
        WAIT_LO = 3'd2,
        REQ_HI  = 3'd3,
        WAIT_HI = 3'd4,
        RESP    = 3'd5
    } state_t;

    state_t             state_r;
    state_t             state_nx_s;

    logic [31:0]        addr_q_r [DEPTH];
    logic [38:0]        tag_q_r  [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W:0]     count_r;

    logic [31:0]        lo_r;
    logic [63:0]        instr_r;
    logic [38:0]        tag_r;
    logic               ack_r;
    logic               ovf_r;

    logic               push_s;
    logic               pop_s;
    logic               fifo_empty_s;
    logic [31:0]        head_addr_s;
    logic               mem_req_s;
    logic [31:0]        mem_addr_s;

    // Full check uses only the count at the start of the cycle; a same-cycle pop never frees a slot.
    assign push_s       = buff_rd_en && (count_r != DEPTH_C);
    assign pop_s        = (state_r == WAIT_HI) && mem_rd_valid;
    assign fifo_empty_s = (count_r == '0);
    assign head_addr_s  = addr_q_r[rd_ptr_r];

    // Request FIFO storage, pointers and occupancy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q_r[i] <= 32'd0;
                tag_q_r[i]  <= 39'd0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_s) begin
                addr_q_r[wr_ptr_r] <= buff_addr;
                tag_q_r[wr_ptr_r]  <= buff_tag;
                wr_ptr_r           <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            count_r <= count_r + (PTR_W + 1)'(push_s) - (PTR_W + 1)'(pop_s);
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic: one read outstanding at a time, lo dword first.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            IDLE: begin
                if (!fifo_empty_s) state_nx_s = REQ_LO;
                else               state_nx_s = IDLE;
            end
            REQ_LO: begin
                if (mem_gnt) state_nx_s = WAIT_LO;
                else         state_nx_s = REQ_LO;
            end
            WAIT_LO: begin
                if (mem_rd_valid) state_nx_s = REQ_HI;
                else              state_nx_s = WAIT_LO;
            end
            REQ_HI: begin
                if (mem_gnt) state_nx_s = WAIT_HI;
                else         state_nx_s = REQ_HI;
            end
            WAIT_HI: begin
                if (mem_rd_valid) state_nx_s = RESP;
                else              state_nx_s = WAIT_HI;
            end
            RESP: begin
                if (!fifo_empty_s) state_nx_s = REQ_LO;
                else               state_nx_s = IDLE;
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // Memory request decode; address held at zero outside the request states.
    always_comb begin
        mem_req_s  = 1'b0;
        mem_addr_s = 32'd0;
        case (state_r)
            REQ_LO: begin
                mem_req_s  = 1'b1;
                mem_addr_s = head_addr_s;
            end
            REQ_HI: begin
                mem_req_s  = 1'b1;
                mem_addr_s = head_addr_s + 32'd4;
            end
            default: begin
                mem_req_s  = 1'b0;
                mem_addr_s = 32'd0;
            end
        endcase
    end

    assign mem_req         = mem_req_s;
    assign mem_addr        = mem_addr_s;
    assign buff2wave_valid = (state_r == RESP);

    // Read data capture; output word and tag change only when the response becomes valid.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lo_r    <= 32'd0;
            instr_r <= 64'd0;
            tag_r   <= 39'd0;
        end else begin
            if ((state_r == WAIT_LO) && mem_rd_valid) begin
                lo_r <= mem_rd_data;
            end
            if (pop_s) begin
                instr_r <= {mem_rd_data, lo_r};
                tag_r   <= tag_q_r[rd_ptr_r];
            end
        end
    end

    // Acceptance pulse and sticky overflow flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_r <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            ack_r <= push_s;
            if (buff_rd_en && !push_s) ovf_r <= 1'b1;
            else                       ovf_r <= ovf_r;
        end
    end

    assign buff_ack        = ack_r;
    assign ibuff_overflow  = ovf_r;
    assign buff2wave_instr = instr_r;
    assign buff2wave_tag   = tag_r;

`ifdef IBUFF_PERF_CNT_EN
    logic [31:0] perf_req_r;
    logic [31:0] perf_stall_r;

    // Performance counters: accepted requests and cycles stalled waiting for grant.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_req_r   <= 32'd0;
            perf_stall_r <= 32'd0;
        end else begin
            if (push_s) perf_req_r <= perf_req_r + 32'd1;
            else        perf_req_r <= perf_req_r;
            if (mem_req_s && !mem_gnt) perf_stall_r <= perf_stall_r + 32'd1;
            else                       perf_stall_r <= perf_stall_r;
        end
    end

    assign perf_req_cnt   = perf_req_r;
    assign perf_stall_cnt = perf_stall_r;
`endif

endmodule

// File: tb/tb_ibuff_mem_ctrl.sv
// Self-checking bench for ibuff_mem_ctrl: a queue-based reference model of
// the request FIFO and a reactive memory responder predict acks, memory
// addresses, responses and the overflow flag cycle by cycle.
module tb_ibuff_mem_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        buff_rd_en;
    logic [31:0] buff_addr;
    logic [38:0] buff_tag;
    logic        buff_ack;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_gnt;
    logic        mem_rd_valid;
    logic [31:0] mem_rd_data;
    logic        buff2wave_valid;
    logic [63:0] buff2wave_instr;
    logic [38:0] buff2wave_tag;
    logic        ibuff_overflow;
`ifdef IBUFF_PERF_CNT_EN
    logic [31:0] perf_req_cnt;
    logic [31:0] perf_stall_cnt;
`endif

    always #5 clk = ~clk;

    ibuff_mem_ctrl #(.DEPTH(4), .PTR_W(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .buff_rd_en      (buff_rd_en),
        .buff_addr       (buff_addr),
        .buff_tag        (buff_tag),
        .buff_ack        (buff_ack),
        .mem_req         (mem_req),
        .mem_addr        (mem_addr),
        .mem_gnt         (mem_gnt),
        .mem_rd_valid    (mem_rd_valid),
        .mem_rd_data     (mem_rd_data),
        .buff2wave_valid (buff2wave_valid),
        .buff2wave_instr (buff2wave_instr),
        .buff2wave_tag   (buff2wave_tag),
        .ibuff_overflow  (ibuff_overflow)
`ifdef IBUFF_PERF_CNT_EN
        ,
        .perf_req_cnt    (perf_req_cnt),
        .perf_stall_cnt  (perf_stall_cnt)
`endif
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [38:0] tag;
    } req_t;

    req_t        mq[$];          // requests accepted but not yet fully read
    logic [102:0] rq[$];         // expected responses {instr, tag}
    logic [31:0] fixed_data[$];  // directed read data, used before random data

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;

    bit          phase_hi, outst, exp_ack, exp_valid, ovf_exp, prev_stall, force_spur;
    int          delay;
    logic [31:0] lo_data, prev_addr, last_hi_addr;
    logic [63:0] last_instr;
    logic [38:0] last_tag;
    int          gnt_pct, dmax, spur_pct, hold_hi;
    int          ack_seen, valid_seen, last_valid_cyc;
    logic [31:0] m_req_cnt, m_stall_cnt;

    task automatic model_reset();
        mq.delete(); rq.delete(); fixed_data.delete();
        phase_hi = 0; outst = 0; exp_ack = 0; exp_valid = 0; ovf_exp = 0;
        prev_stall = 0; force_spur = 0; delay = 0; hold_hi = 0;
        lo_data = 32'd0; prev_addr = 32'd0; last_instr = 64'd0; last_tag = 39'd0;
        m_req_cnt = 32'd0; m_stall_cnt = 32'd0;
    endtask

    // One clock cycle: check this cycle's outputs against the model, then drive inputs.
    task automatic tick(input bit rd, input logic [31:0] a, input logic [38:0] t);
        bit          accept, hi_del;
        logic [31:0] ea, d;
        logic [102:0] r;
        n_checks++;
        if (buff_ack !== exp_ack) begin
            n_fail++; $display("FAIL ack cyc=%0d got=%b exp=%b", cyc, buff_ack, exp_ack);
        end
        if (buff_ack === 1'b1) ack_seen++;
        n_checks++;
        if (ibuff_overflow !== ovf_exp) begin
            n_fail++; $display("FAIL overflow cyc=%0d got=%b exp=%b", cyc, ibuff_overflow, ovf_exp);
        end
        n_checks++;
        if (buff2wave_valid !== exp_valid) begin
            n_fail++; $display("FAIL valid cyc=%0d got=%b exp=%b", cyc, buff2wave_valid, exp_valid);
        end
        if (buff2wave_valid === 1'b1) begin valid_seen++; last_valid_cyc = cyc; end
        if (exp_valid && rq.size() > 0) begin
            r = rq.pop_front();
            last_instr = r[102:39];
            last_tag   = r[38:0];
        end
        n_checks++;
        if (buff2wave_instr !== last_instr || buff2wave_tag !== last_tag) begin
            n_fail++;
            $display("FAIL resp_data cyc=%0d got=%h/%h exp=%h/%h", cyc,
                     buff2wave_instr, buff2wave_tag, last_instr, last_tag);
        end
        if (outst) begin
            n_checks++;
            if (mem_req !== 1'b0) begin
                n_fail++; $display("FAIL one_outstanding cyc=%0d mem_req=%b exp=0", cyc, mem_req);
            end
        end
        if (prev_stall) begin
            n_checks++;
            if (mem_req !== 1'b1 || mem_addr !== prev_addr) begin
                n_fail++;
                $display("FAIL req_stable cyc=%0d got=%b/%h exp=1/%h", cyc, mem_req, mem_addr, prev_addr);
            end
        end
        if (mem_req === 1'b1) begin
            n_checks++;
            if (mq.size() == 0) begin
                n_fail++; $display("FAIL spurious_req cyc=%0d addr=%h exp=no request", cyc, mem_addr);
            end else begin
                ea = phase_hi ? (mq[0].addr + 32'd4) : mq[0].addr;
                if (mem_addr !== ea) begin
                    n_fail++; $display("FAIL mem_addr cyc=%0d got=%h exp=%h", cyc, mem_addr, ea);
                end
            end
        end
`ifdef IBUFF_PERF_CNT_EN
        n_checks++;
        if (perf_req_cnt !== m_req_cnt || perf_stall_cnt !== m_stall_cnt) begin
            n_fail++;
            $display("FAIL perf cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc,
                     perf_req_cnt, perf_stall_cnt, m_req_cnt, m_stall_cnt);
        end
`endif
        // drive this cycle
        accept = rd && (mq.size() < DEPTH);
        hi_del = 0;
        buff_rd_en = rd; buff_addr = a; buff_tag = t;
        mem_gnt = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = $urandom;
        if (outst) begin
            if (delay == 0) begin
                if (fixed_data.size() > 0) d = fixed_data.pop_front();
                else                       d = $urandom;
                mem_rd_valid = 1'b1; mem_rd_data = d;
                if (!phase_hi) begin
                    lo_data = d; phase_hi = 1;
                end else begin
                    rq.push_back({d, lo_data, mq[0].tag});
                    void'(mq.pop_front());
                    phase_hi = 0; hi_del = 1;
                end
                outst = 0;
            end else begin
                delay--;
            end
        end else begin
            if (force_spur || int'($urandom_range(0, 99)) < spur_pct) mem_rd_valid = 1'b1;
            force_spur = 0;
            if (mem_req === 1'b1) begin
                if (phase_hi && hold_hi > 0) begin
                    hold_hi--;
                end else if (int'($urandom_range(0, 99)) < gnt_pct) begin
                    mem_gnt = 1'b1; outst = 1;
                    delay = int'($urandom_range(0, dmax));
                    if (phase_hi) last_hi_addr = mem_addr;
                end
            end
        end
        if (accept) begin mq.push_back({a, t}); m_req_cnt++; end
        if (rd && !accept) ovf_exp = 1;
        exp_ack = accept;
        exp_valid = hi_del;
        prev_stall = (mem_req === 1'b1) && !mem_gnt;
        prev_addr = mem_addr;
        if (prev_stall) m_stall_cnt++;
        cyc++;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((mq.size() != 0 || rq.size() != 0 || exp_valid || outst) && k < 400) begin
            tick(0, 32'd0, 39'd0);
            k++;
        end
        n_checks++;
        if (k >= 400) begin
            n_fail++; $display("FAIL drain_timeout pending=%0d/%0d exp=0/0", mq.size(), rq.size());
        end
    endtask

    // Asserts reset asynchronously mid-cycle and checks every output is cleared at once.
    task automatic apply_reset();
        rst = 1'b1;
        buff_rd_en = 1'b0; buff_addr = 32'd0; buff_tag = 39'd0;
        mem_gnt = 1'b0; mem_rd_valid = 1'b0; mem_rd_data = 32'd0;
        #1;
        n_checks++;
        if (buff_ack !== 1'b0 || mem_req !== 1'b0 || mem_addr !== 32'd0 || buff2wave_valid !== 1'b0 ||
            buff2wave_instr !== 64'd0 || buff2wave_tag !== 39'd0 || ibuff_overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs ack=%b req=%b addr=%h v=%b instr=%h tag=%h ovf=%b exp=all 0",
                     buff_ack, mem_req, mem_addr, buff2wave_valid, buff2wave_instr, buff2wave_tag,
                     ibuff_overflow);
        end
`ifdef IBUFF_PERF_CNT_EN
        n_checks++;
        if (perf_req_cnt !== 32'd0 || perf_stall_cnt !== 32'd0) begin
            n_fail++; $display("FAIL reset_perf got=%0d/%0d exp=0/0", perf_req_cnt, perf_stall_cnt);
        end
`endif
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        for (int i = 0; i < 3; i++) tick(0, 32'd0, 39'd0);
    endtask

    task automatic test_single();
        int start;
        gnt_pct = 100; dmax = 0; spur_pct = 0;
        fixed_data.push_back(32'hAAAA0001);
        fixed_data.push_back(32'hBBBB0002);
        start = cyc;
        tick(1, 32'h0000_0100, 39'h05_0000_0100);
        drain();
        n_checks++;
        if (last_valid_cyc != start + 6) begin
            n_fail++; $display("FAIL single_latency got=%0d exp=%0d", last_valid_cyc - start, 6);
        end
        n_checks++;
        if (buff2wave_instr !== 64'hBBBB0002_AAAA0001 || buff2wave_tag !== 39'h05_0000_0100) begin
            n_fail++; $display("FAIL single_data got=%h/%h exp=bbbb0002aaaa0001/0500000100",
                               buff2wave_instr, buff2wave_tag);
        end
        n_checks++;
        if (last_hi_addr !== 32'h0000_0104) begin
            n_fail++; $display("FAIL single_hi_addr got=%h exp=00000104", last_hi_addr);
        end
    endtask

    task automatic test_back_to_back();
        gnt_pct = 70; dmax = 2; spur_pct = 10;
        ack_seen = 0; valid_seen = 0;
        for (int i = 0; i < 4; i++) tick(1, $urandom & 32'hFFFF_FFFC, {7'(i), 32'h1000 + 32'(i)});
        drain();
        n_checks++;
        if (ack_seen != 4 || valid_seen != 4 || ibuff_overflow !== 1'b0) begin
            n_fail++; $display("FAIL back_to_back acks=%0d resps=%0d ovf=%b exp=4/4/0",
                               ack_seen, valid_seen, ibuff_overflow);
        end
    endtask

    task automatic test_wrap();
        gnt_pct = 100; dmax = 1; spur_pct = 0;
        last_hi_addr = 32'h1234_5678;
        tick(1, 32'hFFFF_FFFC, 39'h7F_FFFF_FFFC);
        drain();
        n_checks++;
        if (last_hi_addr !== 32'h0000_0000) begin
            n_fail++; $display("FAIL wrap_addr got=%h exp=00000000", last_hi_addr);
        end
    endtask

    task automatic test_grant_stall();
`ifdef IBUFF_PERF_CNT_EN
        logic [31:0] s0;
        s0 = perf_stall_cnt;
`endif
        gnt_pct = 100; dmax = 0; spur_pct = 0; hold_hi = 10;
        valid_seen = 0;
        tick(1, 32'h0000_2000, 39'h01_0000_2000);
        drain();
        n_checks++;
        if (hold_hi != 0 || valid_seen != 1) begin
            n_fail++; $display("FAIL stall_resp hold_left=%0d resps=%0d exp=0/1", hold_hi, valid_seen);
        end
`ifdef IBUFF_PERF_CNT_EN
        n_checks++;
        if (perf_stall_cnt - s0 !== 32'd10) begin
            n_fail++; $display("FAIL stall_count got=%0d exp=10", perf_stall_cnt - s0);
        end
`endif
    endtask

    task automatic test_random();
        gnt_pct = 60; dmax = 3; spur_pct = 20;
        for (int i = 0; i < 400; i++) begin
            tick(($urandom_range(0, 99) < 40), $urandom, {7'($urandom), 32'($urandom)});
        end
        drain();
    endtask

    task automatic test_overflow();
        gnt_pct = 0; dmax = 0; spur_pct = 0;
        ack_seen = 0; valid_seen = 0;
        for (int i = 0; i < 5; i++) tick(1, 32'h0000_4000 + 32'(8 * i), {7'h11, 32'(i)});
        tick(0, 32'd0, 39'd0);
        n_checks++;
        if (ack_seen != 4 || ibuff_overflow !== 1'b1) begin
            n_fail++; $display("FAIL overflow_acks acks=%0d ovf=%b exp=4/1", ack_seen, ibuff_overflow);
        end
        gnt_pct = 100; dmax = 1;
        drain();
        for (int i = 0; i < 5; i++) tick(0, 32'd0, 39'd0);
        n_checks++;
        if (valid_seen != 4 || ibuff_overflow !== 1'b1) begin
            n_fail++; $display("FAIL overflow_resps resps=%0d ovf=%b exp=4/1", valid_seen, ibuff_overflow);
        end
    endtask

    task automatic test_reset_mid();
        int k;
        gnt_pct = 100; dmax = 4; spur_pct = 0;
        tick(1, 32'h0000_3000, 39'h02_0000_3000);
        k = 0;
        while (!(outst && !phase_hi) && k < 20) begin
            tick(0, 32'd0, 39'd0);
            k++;
        end
        n_checks++;
        if (k >= 20) begin
            n_fail++; $display("FAIL reach_wait_lo cycles=%0d exp=<20", k);
        end
        apply_reset();
        valid_seen = 0;
        force_spur = 1;
        for (int i = 0; i < 10; i++) tick(0, 32'd0, 39'd0);
        n_checks++;
        if (valid_seen != 0 || mem_req !== 1'b0 || buff2wave_instr !== 64'd0 || buff2wave_tag !== 39'd0) begin
            n_fail++; $display("FAIL reset_mid resps=%0d req=%b instr=%h tag=%h exp=0/0/0/0",
                               valid_seen, mem_req, buff2wave_instr, buff2wave_tag);
        end
    endtask

    initial begin
        rst = 1'b1;
        model_reset();
        gnt_pct = 100; dmax = 0; spur_pct = 0;
        ack_seen = 0; valid_seen = 0; last_valid_cyc = 0; last_hi_addr = 32'd0;
        #2;
        test_reset();
        test_single();
        test_back_to_back();
        test_wrap();
        test_grant_stall();
        test_random();
        test_overflow();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
